prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream (from the UART RX path) and writes 16-bit instruction words into the program RAM that the CPU fetch port reads.
- Holds the CPU in reset while loading and releases it only after a verified image.
- Sits between the byte source, the program RAM write port and the CPU reset input.

Parameters:
ADDR_W, 16, program memory address width; max image = 2^ADDR_W words.
TIMEOUT_CYCLES, 1000000, max clk cycles between accepted bytes inside a frame before abort.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse: re-enter load mode from DONE.
in_valid  in  1  byte available.
in_data  in  8  byte value.
in_ready  out  1  loader accepts byte; transfer when in_valid & in_ready.
mem_we  out  1  program RAM write strobe, one cycle per word.
mem_addr  out  ADDR_W  write address.
mem_wdata  out  16  write data.
cpu_rst_n  out  1  CPU reset, active-low; 0 while loading.
busy  out  1  frame in progress.
done  out  1  image loaded and verified.
error  out  1  last frame failed (sticky).
words_written  out  ADDR_W+1  words written in current/last frame.

Behaviour:
- Frame format: 0xA5 sync, count_hi, count_lo, then 2*N data bytes (big-endian, high byte first per word), then checksum byte.
  - N = {count_hi, count_lo}.
  - Checksum = 8-bit modulo-256 sum of all data bytes.
- Reset values:
  - FSM in IDLE, cpu_rst_n=0.
  - mem_we, busy, done, error = 0.
  - mem_addr, mem_wdata, words_written = 0; in_ready=1.
- States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE. All outputs registered except in_ready.
- in_ready = 1 in every state except DONE (no backpressure from RAM; single-cycle write).
- IDLE:
  - Non-0xA5 bytes are accepted and discarded.
  - 0xA5 → CNT_HI: error:=0, busy:=1, words_written:=0, sum:=0, mem_addr:=0.
- CNT_HI → CNT_LO on byte.
- CNT_LO, on byte:
  - If N==0 or N>2^ADDR_W → error:=1, busy:=0, go to IDLE.
  - Else → DATA_HI.
- DATA_HI: latch high byte, add to sum → DATA_LO.
- DATA_LO: add to sum.
  - Next cycle: mem_we=1 (exactly one cycle), mem_wdata={hi,lo}, mem_addr = current word index; words_written increments in the same cycle.
  - mem_addr advances after the strobe.
  - If this was word N → CHECK, else → DATA_HI.
- CHECK, on byte:
  - Byte == sum → DONE: done:=1, busy:=0, cpu_rst_n:=1.
  - Byte != sum → IDLE: error:=1, busy:=0, cpu_rst_n stays 0.
  - RAM contents written so far are not rolled back.
- DONE:
  - in_ready=0; holds outputs.
  - start pulse → IDLE next cycle, cpu_rst_n:=0 and done:=0 in that same edge.
  - start is ignored in all other states.
- Timeout:
  - Counter clears on every accepted byte and on entering CNT_HI.
  - Counts only in CNT_HI..CHECK.
  - Reaching TIMEOUT_CYCLES → IDLE, error:=1, busy:=0.
- Simultaneous byte acceptance and timeout in the same cycle: byte wins, counter clears.
- Address wrap: mem_addr never wraps; bounded by the N check.
- words_written reaches at most 2^ADDR_W.
- Async reset mid-frame: immediate return to reset values. Frame is lost; cpu_rst_n=0.
- in_valid gaps of any length below TIMEOUT_CYCLES are legal; no byte is double-counted.

Test Plan:
- Nominal load: stream A5 00 03 70 FF 80 02 80 01 72 → three mem_we pulses writing 0x0000=70FF, 0x0001=8002, 0x0002=8001; done=1, cpu_rst_n=1, words_written=3, in_ready=0, error=0.
- Bad checksum: same frame ending 73 → three writes occur; error=1, done=0, cpu_rst_n=0, FSM in IDLE. Then a correct frame → error clears on A5, done=1.
- Sync hunt plus zero count: 00 FF 13 before A5 00 01 12 34 46 → leading bytes discarded, one write 0x0000=1234, done=1. Separately, A5 00 00 → error=1 and no mem_we.
- Backpressure and timeout: nominal frame with random 0–20 cycle in_valid gaps → identical result. With TIMEOUT_CYCLES=100, stall 100 cycles after the 5th byte → error=1, busy=0, exactly one write issued.
- Reload: after done, pulse start → cpu_rst_n=0, done=0 next cycle, in_ready=1. A new frame loads and releases the CPU again.
- Reset mid-frame: assert rst_n=0 between the DATA_HI and DATA_LO bytes → outputs at reset values asynchronously. No mem_we issued for the partial word.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: turns a framed byte stream (A5, count, data, checksum) into
// 16-bit program RAM writes and holds the CPU in reset until a verified image is in.
module prog_loader #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written,
    output logic [2:0]        dbg_state
);
    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CNT_HI  = 3'd1,
        S_CNT_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt_hi;
    logic [7:0]        r_data_hi;
    logic [7:0]        r_sum;
    logic [CW-1:0]     r_count;
    logic [TW-1:0]     r_tmo;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_cpu_rst_n;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [CW-1:0]     r_words_written;

    logic [15:0]       w_n;
    logic              w_n_bad;
    logic              w_accept;
    logic              w_active;
    logic              w_timeout;
    logic [CW-1:0]     w_ww_next;

    // A byte transfers on any edge where in_valid && in_ready; in_ready drops only in DONE.
    assign in_ready  = (r_state != S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_n       = {r_cnt_hi, in_data};
    assign w_n_bad   = (w_n == 16'd0) || (64'(w_n) > (64'd1 << ADDR_W));
    assign w_active  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_timeout = w_active && !w_accept && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_ww_next = r_words_written + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt_hi        <= '0;
            r_data_hi       <= '0;
            r_sum           <= '0;
            r_count         <= '0;
            r_tmo           <= '0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_cpu_rst_n     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_words_written <= '0;
        end else begin
            r_mem_we <= 1'b0;
            // Step past the word just strobed, but never beyond the last word of the frame.
            if (r_mem_we && (r_words_written != r_count))
                r_mem_addr <= r_mem_addr + ADDR_W'(1);

            if (w_accept || !w_active)
                r_tmo <= '0;
            else if (!w_timeout)
                r_tmo <= r_tmo + TW'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_accept && (in_data == 8'hA5)) begin
                        r_state         <= S_CNT_HI;
                        r_error         <= 1'b0;
                        r_busy          <= 1'b1;
                        r_words_written <= '0;
                        r_sum           <= '0;
                        r_mem_addr      <= '0;
                    end
                end
                S_CNT_HI: begin
                    if (w_accept) begin
                        r_cnt_hi <= in_data;
                        r_state  <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (w_accept) begin
                        if (w_n_bad) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= CW'(w_n);
                            r_state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_accept) begin
                        r_data_hi <= in_data;
                        r_sum     <= r_sum + in_data;
                        r_state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (w_accept) begin
                        r_sum           <= r_sum + in_data;
                        r_mem_we        <= 1'b1;
                        r_mem_wdata     <= {r_data_hi, in_data};
                        r_words_written <= w_ww_next;
                        r_state         <= (w_ww_next == r_count) ? S_CHECK : S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_busy <= 1'b0;
                        if (in_data == r_sum) begin
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_cpu_rst_n <= 1'b0;
                        r_done      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_timeout) begin
                r_state <= S_IDLE;
                r_error <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign cpu_rst_n     = r_cpu_rst_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words_written;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from word lists, expected RAM writes are
// queued as each frame is built and retired as mem_we strobes are observed.
module tb_prog_loader;
    localparam int AW  = 4;
    localparam int CW  = AW + 1;
    localparam int TMO = 100;

    localparam int ST_IDLE    = 0;
    localparam int ST_DATA_HI = 3;
    localparam int ST_DATA_LO = 4;
    localparam int ST_DONE    = 6;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] words_written;
    logic [2:0]    dbg_state;

    logic [AW+15:0] exp_q[$];
    logic [7:0]     frame_q[$];
    logic [15:0]    word_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int n_we  = 0;
    int n0;

    prog_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
        .words_written(words_written), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock step; every strobe seen on mem_we is retired against the expected queue.
    task automatic tick();
        logic [AW+15:0] e;
        @(negedge clk);
        if (mem_we === 1'b1) begin
            n_we++;
            if (exp_q.size() == 0) begin
                check("exp_q_nonempty", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[AW+15:16]));
                check("wr_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'(in_ready), 1);
    endtask

    task automatic build_frame(input bit bad_sum);
        logic [7:0] s;
        int n;
        s = 8'h00;
        n = word_q.size();
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        foreach (word_q[i]) begin
            frame_q.push_back(word_q[i][15:8]);
            frame_q.push_back(word_q[i][7:0]);
            s = s + word_q[i][15:8] + word_q[i][7:0];
            exp_q.push_back({AW'(i), word_q[i]});
        end
        frame_q.push_back(bad_sum ? s + 8'd1 : s);
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], int'($urandom_range(max_gap, 0)));
            if (i == 0) begin
                check("sync_busy", 32'(busy), 1);
                check("sync_err_clr", 32'(error), 0);
            end
        end
    endtask

    task automatic check_done(input int ww);
        check("done", 32'(done), 1);
        check("cpu_rst_n_rel", 32'(cpu_rst_n), 1);
        check("in_ready_done", 32'(in_ready), 0);
        check("error_done", 32'(error), 0);
        check("busy_done", 32'(busy), 0);
        check("words_written", 32'(words_written), 32'(ww));
        check("state_done", 32'(dbg_state), ST_DONE);
        check("exp_q_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic check_err_idle();
        check("error_set", 32'(error), 1);
        check("busy_clr", 32'(busy), 0);
        check("done_clr", 32'(done), 0);
        check("cpu_held", 32'(cpu_rst_n), 0);
        check("state_idle", 32'(dbg_state), ST_IDLE);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_done", 32'(done), 0);
        check("start_cpu", 32'(cpu_rst_n), 0);
        check("start_ready", 32'(in_ready), 1);
        check("start_state", 32'(dbg_state), ST_IDLE);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_cpu", 32'(cpu_rst_n), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_ww", 32'(words_written), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_state", 32'(dbg_state), ST_IDLE);
        rst_n = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ign_state", 32'(dbg_state), ST_IDLE);
        check("start_ign_cpu", 32'(cpu_rst_n), 0);

        // Nominal image
        word_q = '{16'h70FF, 16'h8002, 16'h8001};
        n0 = n_we;
        build_frame(1'b0);
        send_frame(0);
        check_done(3);
        check("nom_we_cnt", 32'(n_we - n0), 3);
        check("nom_last_addr", 32'(mem_addr), 2);

        // Bytes offered in DONE must not be taken
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) tick();
        in_valid = 1'b0;
        check("done_hold_state", 32'(dbg_state), ST_DONE);
        check("done_hold_busy", 32'(busy), 0);
        do_start();

        // Bad checksum, then the same image with random gaps
        n0 = n_we;
        build_frame(1'b1);
        send_frame(0);
        check_err_idle();
        check("bad_we_cnt", 32'(n_we - n0), 3);
        build_frame(1'b0);
        send_frame(20);
        check_done(3);
        do_start();

        // Sync hunt
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h13, 0);
        check("hunt_busy", 32'(busy), 0);
        check("hunt_state", 32'(dbg_state), ST_IDLE);
        word_q = '{16'h1234};
        build_frame(1'b0);
        send_frame(2);
        check_done(1);
        do_start();

        // Count bounds: 0 and one past the memory size are rejected
        n0 = n_we;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (2) tick();
        check_err_idle();
        check("zero_no_we", 32'(n_we - n0), 0);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        check_err_idle();

        // Full memory: 16 words
        word_q.delete();
        for (int i = 0; i < 16; i++) word_q.push_back(16'($urandom));
        build_frame(1'b0);
        send_frame(3);
        check_done(16);
        check("full_last_addr", 32'(mem_addr), 15);
        do_start();

        // Timeout: stall after the fifth byte
        n0 = n_we;
        exp_q.push_back({AW'(0), 16'h70FF});
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h70, 0);
        send_byte(8'hFF, 0);
        repeat (TMO - 1) tick();
        check("tmo_pre_busy", 32'(busy), 1);
        check("tmo_pre_state", 32'(dbg_state), ST_DATA_HI);
        check("tmo_pre_err", 32'(error), 0);
        tick();
        check_err_idle();
        check("tmo_we_cnt", 32'(n_we - n0), 1);
        check("tmo_exp_drained", 32'(exp_q.size()), 0);

        // Asynchronous reset between DATA_HI and DATA_LO bytes
        n0 = n_we;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        check("mid_state", 32'(dbg_state), ST_DATA_LO);
        check("mid_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_state", 32'(dbg_state), ST_IDLE);
        check("arst_wdata", 32'(mem_wdata), 0);
        check("arst_cpu", 32'(cpu_rst_n), 0);
        check("arst_error", 32'(error), 0);
        check("arst_ready", 32'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("arst_no_we", 32'(n_we - n0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
